// File: rtl/wishbone_bus_if.sv
// Wishbone classic master bridge for one CPU memory port.
//
// A CPU request (cpu_ce_i with address, data, write enable and byte lanes) becomes a single
// Wishbone classic transaction. The bridge asks the pipeline to stall until the slave acks.
// If the pipeline is still frozen by another stage when the ack arrives, the read data is
// held in a buffer so the bus is not accessed again. A flush abandons the current request.
//
// Optional feature macro: WB_TIMEOUT_EN. When defined, a BUSY cycle counter aborts a transaction
// that gets no ack within TIMEOUT_CYCLES cycles. The abort returns 32'hFFFF_FFFF as read data
// and pulses bus_err_o for one cycle. When undefined, BUSY waits indefinitely and bus_err_o is 0.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   cpu_ce_i                CPU request valid
//   cpu_addr_i/cpu_data_i   byte address / write data
//   cpu_we_i, cpu_sel_i     1=write, byte lanes (bit3 = [31:24])
//   cpu_data_o              read data to CPU (combinational)
//   stall_i, flush_i        pipeline frozen by any stage / pipeline flush
//   stallreq_o              stall request to pipeline control (combinational)
//   wishbone_*_o            registered bus outputs (addr, data, we, sel, stb, cyc)
//   wishbone_data_i/ack_i   bus read data / acknowledge
//   bus_err_o               timeout abort pulse (WB_TIMEOUT_EN only)
module wishbone_bus_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i,
  output logic        bus_err_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StWaitForStall
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        stb_q, stb_d;
  logic        cyc_q, cyc_d;
  logic [31:0] rd_buf_q, rd_buf_d;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;

  assign bus_err_o = bus_err_q;
`else
  assign bus_err_o = 1'b0;
`endif

  assign wishbone_addr_o = addr_q;
  assign wishbone_data_o = data_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_sel_o  = sel_q;
  assign wishbone_stb_o  = stb_q;
  assign wishbone_cyc_o  = cyc_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    sel_d      = sel_q;
    stb_d      = stb_q;
    cyc_d      = cyc_q;
    rd_buf_d   = rd_buf_q;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
`ifdef WB_TIMEOUT_EN
    cnt_d      = cnt_q;
    bus_err_d  = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          addr_d  = cpu_addr_i;
          data_d  = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          state_d = StBusy;
`ifdef WB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      StBusy: begin
        if (flush_i) begin
          // Abandon the request; any read data this cycle is dropped.
          addr_d  = '0;
          data_d  = '0;
          we_d    = 1'b0;
          sel_d   = '0;
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          state_d = StIdle;
        end else if (wishbone_ack_i) begin
          cpu_data_o = we_q ? 32'h0 : wishbone_data_i;
          addr_d     = '0;
          data_d     = '0;
          we_d       = 1'b0;
          sel_d      = '0;
          stb_d      = 1'b0;
          cyc_d      = 1'b0;
          rd_buf_d   = wishbone_data_i;
          // If another stage holds the pipeline, park the data instead of re-issuing.
          state_d    = stall_i ? StWaitForStall : StIdle;
`ifdef WB_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          cpu_data_o = 32'hFFFF_FFFF;
          addr_d     = '0;
          data_d     = '0;
          we_d       = 1'b0;
          sel_d      = '0;
          stb_d      = 1'b0;
          cyc_d      = 1'b0;
          rd_buf_d   = 32'hFFFF_FFFF;
          bus_err_d  = 1'b1;
          state_d    = stall_i ? StWaitForStall : StIdle;
        end else begin
          stallreq_o = 1'b1;
          cnt_d      = cnt_q + 1'b1;
        end
`else
        end else begin
          stallreq_o = 1'b1;
        end
`endif
      end

      StWaitForStall: begin
        cpu_data_o = rd_buf_q;
        if (flush_i || !stall_i) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      stb_q    <= 1'b0;
      cyc_q    <= 1'b0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      stb_q    <= stb_d;
      cyc_q    <= cyc_d;
      rd_buf_q <= rd_buf_d;
    end
  end

`ifdef WB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Bench for wishbone_bus_if: a RAM slave with programmable ack delay, a CPU-side driver,
// a reference memory updated with byte-lane arithmetic, and a scoreboard monitor that
// compares cpu_data_o whenever the bridge presents data to the CPU.
module tb_wishbone_bus_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic        cpu_we_i = 1'b0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_o;
  logic        stall_i;
  logic        flush_i = 1'b0;
  logic        stallreq_o;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;
  logic [31:0] wishbone_data_i;
  logic        wishbone_ack_i;
  logic        bus_err_o;

  logic        ext_stall = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          slave_delay = 0;
  bit          slave_mute = 1'b0;
  bit          exp_timeout = 1'b0;
  int          s_cnt;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_q [$];

  wishbone_bus_if #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_ce_i        (cpu_ce_i),
    .cpu_addr_i      (cpu_addr_i),
    .cpu_data_i      (cpu_data_i),
    .cpu_we_i        (cpu_we_i),
    .cpu_sel_i       (cpu_sel_i),
    .cpu_data_o      (cpu_data_o),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .stallreq_o      (stallreq_o),
    .wishbone_addr_o (wishbone_addr_o),
    .wishbone_data_o (wishbone_data_o),
    .wishbone_we_o   (wishbone_we_o),
    .wishbone_sel_o  (wishbone_sel_o),
    .wishbone_stb_o  (wishbone_stb_o),
    .wishbone_cyc_o  (wishbone_cyc_o),
    .wishbone_data_i (wishbone_data_i),
    .wishbone_ack_i  (wishbone_ack_i),
    .bus_err_o       (bus_err_o)
  );

  always #5 clk = ~clk;

  // The pipeline is frozen by this stage's own request or by some other stage.
  assign stall_i = stallreq_o | ext_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // RAM slave: acks slave_delay cycles after stb rises, ack combinational.
  assign wishbone_ack_i = wishbone_cyc_o && wishbone_stb_o && !slave_mute &&
                          (s_cnt == slave_delay);
  assign wishbone_data_i = (wishbone_ack_i && !wishbone_we_o) ? mem[wishbone_addr_o[5:2]] : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (wishbone_cyc_o && wishbone_stb_o) begin
      if (wishbone_ack_i) begin
        s_cnt <= 0;
        if (wishbone_we_o) begin
          mem[wishbone_addr_o[5:2]] <= merge(mem[wishbone_addr_o[5:2]], wishbone_data_o,
                                             wishbone_sel_o);
        end
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else begin
      s_cnt <= 0;
    end
  end

  // Scoreboard: data is consumed on a cycle where the pipeline is not stalled; while frozen
  // with the request answered, the held value must already match the pending expectation.
  always @(negedge clk) begin
    if (rst_n && cpu_ce_i && !stallreq_o && !flush_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data: got %h, expected no delivery", cpu_data_o);
      end else if (!stall_i) begin
        check("read_data", cpu_data_o, exp_q.pop_front());
      end else begin
        check("held_data", cpu_data_o, exp_q[0]);
      end
    end
  end

  // Issue one request; hold = WAIT cycles forced by another stage, flush_at = BUSY cycle
  // index at which to flush (-1 for none, must precede the ack).
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel, input int dly, input int hold, input int flush_at);
    int n = 0, held = 0, busy = 0, stb_hi = 0, rises = 0, errs = 0, idx;
    bit done = 1'b0, prev_stb = 1'b0, drop = 1'b0, flushed = 1'b0;
    logic [31:0] expv;
    idx = int'(addr[5:2]);
    if (exp_timeout) expv = 32'hFFFF_FFFF;
    else expv = we ? 32'h0 : ref_mem[idx];
    exp_q.push_back(expv);
    slave_delay = dly;
    cpu_ce_i   = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = data;
    cpu_sel_i  = sel;
    ext_stall  = (hold > 0);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (bus_err_o) errs++;
      if (wishbone_stb_o && !prev_stb) begin
        rises++;
        check("wb_addr", wishbone_addr_o, addr);
        check("wb_we", 32'(wishbone_we_o), 32'(we));
        check("wb_sel", 32'(wishbone_sel_o), 32'(sel));
        if (we) check("wb_data", wishbone_data_o, data);
      end
      prev_stb = wishbone_stb_o;
      if (wishbone_stb_o) stb_hi++;
      if (wishbone_cyc_o && flush_at == busy) begin
        flush_i = 1'b1;
        #1;
        check("flush_stallreq", 32'(stallreq_o), 32'h0);
        check("flush_data", cpu_data_o, 32'h0);
        @(posedge clk);
        #1;
        check("flush_cyc_stb", 32'({wishbone_cyc_o, wishbone_stb_o}), 32'h0);
        flush_i   = 1'b0;
        cpu_ce_i  = 1'b0;
        ext_stall = 1'b0;
        void'(exp_q.pop_back());
        flushed = 1'b1;
        done    = 1'b1;
      end else begin
        if (wishbone_cyc_o) busy++;
        if (!stallreq_o && !stall_i) begin
          done = 1'b1;
        end else if (!stallreq_o && ext_stall) begin
          held++;
          if (held > hold) drop = 1'b1;
        end
        @(posedge clk);
        #1;
        if (drop) ext_stall = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no completion in %0d cycles, expected completion", n);
      cpu_ce_i  = 1'b0;
      ext_stall = 1'b0;
    end else if (!flushed) begin
      check("stb_rises", rises, 1);
      check("stb_cycles", stb_hi, dly + 1);
      if (hold == 0) check("latency", n, dly + 2);
      check("bus_err_pulses", errs, exp_timeout ? 1 : 0);
      if (we && !exp_timeout) ref_mem[idx] = merge(ref_mem[idx], data, sel);
    end
  endtask

  task automatic idle(input int k);
    cpu_ce_i  = 1'b0;
    ext_stall = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    bit we;
    logic [31:0] a, d;
    logic [3:0] s;
    int dly, hold, fl;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    #12;
    check("rst_cyc_stb", 32'({wishbone_cyc_o, wishbone_stb_o, wishbone_we_o}), 32'h0);
    check("rst_addr", wishbone_addr_o, 32'h0);
    check("rst_sel_data", wishbone_data_o | 32'(wishbone_sel_o), 32'h0);
    check("rst_stallreq", 32'(stallreq_o), 32'h0);
    check("rst_cpu_data", cpu_data_o, 32'h0);
    check("rst_bus_err", 32'(bus_err_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-word write then read back, single-cycle slave.
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, -1);
    idle(1);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 0, 0, -1);
    idle(1);
    // Byte-lane merge.
    do_req(1'b1, 32'h20, 32'h1122_3344, 4'hF, 1, 0, -1);
    do_req(1'b1, 32'h20, 32'h00AB_0000, 4'b0100, 0, 0, -1);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 2, 0, -1);
    idle(2);
    // Ack while another stage holds the pipeline for 3 cycles.
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 0, 3, -1);
    idle(1);
    // Back-to-back reads with cpu_ce_i held.
    do_req(1'b1, 32'h0, 32'hA5A5_0000, 4'hF, 0, 0, -1);
    do_req(1'b1, 32'h4, 32'h0000_5A5A, 4'hF, 0, 0, -1);
    do_req(1'b0, 32'h0, 32'h0, 4'hF, 1, 0, -1);
    do_req(1'b0, 32'h4, 32'h0, 4'hF, 1, 0, -1);
    idle(1);
    // Flush in BUSY before a delayed ack, then a clean follow-up read.
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 3, 0, 0);
    idle(2);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 1, 0, -1);
    idle(1);

    // Asynchronous reset in the middle of BUSY.
    slave_delay = 10;
    cpu_ce_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h8;
    @(negedge clk);
    @(negedge clk);
    check("busy_cyc_before_rst", 32'(wishbone_cyc_o), 32'h1);
    #2;
    rst_n = 1'b0;
    cpu_ce_i = 1'b0;
    #1;
    check("async_rst_cyc_stb", 32'({wishbone_cyc_o, wishbone_stb_o}), 32'h0);
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int it = 0; it < 60; it++) begin
      we   = 1'($urandom_range(0, 1));
      a    = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      d    = $urandom;
      s    = we ? 4'($urandom_range(1, 15)) : 4'hF;
      dly  = int'($urandom_range(0, 4));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      fl   = (dly > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, dly - 1)) : -1;
      do_req(we, a, d, s, dly, hold, fl);
      idle(int'($urandom_range(0, 2)));
    end

`ifdef WB_TIMEOUT_EN
    idle(1);
    slave_mute  = 1'b1;
    exp_timeout = 1'b1;
    do_req(1'b0, 32'h8, 32'h0, 4'hF, 7, 2, -1);
    slave_mute  = 1'b0;
    exp_timeout = 1'b0;
`endif

    idle(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
